// File: rtl/multiplier_nbit_pipe_hs.sv
// Pipelined WIDTH x WIDTH multiplier, per-item signed/unsigned, valid/ready on both sides.
// Define MULT_ROUND_EN to add the registered round-half-up output q_rnd.
module multiplier_nbit_pipe_hs #(
  parameter int WIDTH   = 16,
  parameter int LATENCY = 3,
  parameter int SHIFT   = 8
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               in_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_q
`ifdef MULT_ROUND_EN
  ,
  output logic [2*WIDTH-SHIFT-1:0] q_rnd
`endif
);

  localparam int EW        = WIDTH + 1;        // extended operand width
  localparam int LW        = (WIDTH + 1) / 2;  // low half, ceil(WIDTH/2)
  localparam int HW        = EW - LW;          // signed high half
  localparam int PW        = 2 * WIDTH + 2;    // partial-product working width
  localparam int OW        = 2 * WIDTH;        // product width
  localparam int SUM_STAGE = (LATENCY == 2) ? 2 : 3;

  // Handshake: a transfer happens on a rising edge where valid & ready are both 1.
  // The whole pipe moves together (adv); a stalled output freezes every stage,
  // so bubbles are kept and out_q/out_valid hold while out_ready is low.
  logic               adv;
  logic [LATENCY:1]   v_q;
  logic [LATENCY:1]   v_d;

  assign adv       = ~out_valid | out_ready;
  assign in_ready  = adv & rstn;
  assign out_valid = v_q[LATENCY];
  assign v_d       = {v_q[LATENCY-1:1], in_valid};

  // Stage 1: extend per mode, then split into signed high / unsigned low halves.
  logic [EW-1:0] a_ext;
  logic [EW-1:0] b_ext;
  logic [HW-1:0] ah_q, bh_q, ah_d, bh_d;
  logic [LW-1:0] al_q, bl_q, al_d, bl_d;

  assign a_ext = {in_signed & a[WIDTH-1], a};
  assign b_ext = {in_signed & b[WIDTH-1], b};
  assign ah_d  = a_ext[EW-1:LW];
  assign al_d  = a_ext[LW-1:0];
  assign bh_d  = b_ext[EW-1:LW];
  assign bl_d  = b_ext[LW-1:0];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      v_q  <= '0;
      ah_q <= '0;
      al_q <= '0;
      bh_q <= '0;
      bl_q <= '0;
    end else if (adv) begin
      v_q  <= v_d;
      ah_q <= ah_d;
      al_q <= al_d;
      bh_q <= bh_d;
      bl_q <= bl_d;
    end
  end

  // Partial products, all computed modulo 2^PW which is wider than any result.
  logic signed [PW-1:0] ah_x, al_x, bh_x, bl_x;
  logic signed [PW-1:0] pp_hh_d, pp_hl_d, pp_lh_d, pp_ll_d;

  assign ah_x    = {{(PW-HW){ah_q[HW-1]}}, ah_q};
  assign bh_x    = {{(PW-HW){bh_q[HW-1]}}, bh_q};
  assign al_x    = {{(PW-LW){1'b0}}, al_q};
  assign bl_x    = {{(PW-LW){1'b0}}, bl_q};
  assign pp_hh_d = ah_x * bh_x;
  assign pp_hl_d = ah_x * bl_x;
  assign pp_lh_d = al_x * bh_x;
  assign pp_ll_d = al_x * bl_x;

  logic signed [PW-1:0] s_hh, s_hl, s_lh, s_ll;

  generate
    if (LATENCY == 2) begin : g_direct
      assign s_hh = pp_hh_d;
      assign s_hl = pp_hl_d;
      assign s_lh = pp_lh_d;
      assign s_ll = pp_ll_d;
    end else begin : g_pp_reg
      logic signed [PW-1:0] pp_hh_q, pp_hl_q, pp_lh_q, pp_ll_q;

      always_ff @(posedge clk) begin
        if (!rstn) begin
          pp_hh_q <= '0;
          pp_hl_q <= '0;
          pp_lh_q <= '0;
          pp_ll_q <= '0;
        end else if (adv) begin
          pp_hh_q <= pp_hh_d;
          pp_hl_q <= pp_hl_d;
          pp_lh_q <= pp_lh_d;
          pp_ll_q <= pp_ll_d;
        end
      end

      assign s_hh = pp_hh_q;
      assign s_hl = pp_hl_q;
      assign s_lh = pp_lh_q;
      assign s_ll = pp_ll_q;
    end
  endgenerate

  logic [OW-1:0] sum_d;

  assign sum_d = OW'((s_hh <<< (2 * LW)) + ((s_hl + s_lh) <<< LW) + s_ll);

  // Result stage followed by plain delay stages up to LATENCY.
  logic [OW-1:0] res_q [SUM_STAGE:LATENCY];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int s = SUM_STAGE; s <= LATENCY; s++) res_q[s] <= '0;
    end else if (adv) begin
      res_q[SUM_STAGE] <= sum_d;
      for (int s = SUM_STAGE + 1; s <= LATENCY; s++) res_q[s] <= res_q[s-1];
    end
  end

  assign out_q = res_q[LATENCY];

`ifdef MULT_ROUND_EN
  localparam int RW = OW - SHIFT;

  // Only bits [OW-1:SHIFT] of the biased sum survive, so an arithmetic and a
  // logical shift give identical bits here; the mode needs no separate path.
  logic [OW-1:0] biased;
  logic [RW-1:0] rnd_d;
  logic [RW-1:0] rnd_q [SUM_STAGE:LATENCY];

  assign biased = sum_d + (OW'(1) << (SHIFT - 1));
  assign rnd_d  = RW'(biased >> SHIFT);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int s = SUM_STAGE; s <= LATENCY; s++) rnd_q[s] <= '0;
    end else if (adv) begin
      rnd_q[SUM_STAGE] <= rnd_d;
      for (int s = SUM_STAGE + 1; s <= LATENCY; s++) rnd_q[s] <= rnd_q[s-1];
    end
  end

  assign q_rnd = rnd_q[LATENCY];
`endif

endmodule

// File: tb/tb_multiplier_nbit_pipe_hs.sv
// Bench for multiplier_nbit_pipe_hs (WIDTH=16, LATENCY=3, SHIFT=8): directed steps
// plus a random stream, results checked through an expected-value queue.
module tb_multiplier_nbit_pipe_hs;

  localparam int WIDTH   = 16;
  localparam int LATENCY = 3;
  localparam int SHIFT   = 8;

  logic        clk       = 1'b0;
  logic        rstn      = 1'b0;
  logic        in_valid  = 1'b0;
  logic        in_signed = 1'b0;
  logic [15:0] a         = '0;
  logic [15:0] b         = '0;
  logic        ordy_fix  = 1'b1;
  logic        ordy_rand = 1'b1;
  logic        rand_en   = 1'b0;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_q;
`ifdef MULT_ROUND_EN
  logic [23:0] q_rnd;
`endif

  // Entry layout: {rounded[23:0], product[31:0]}
  logic [55:0] exp_q[$];
  logic [55:0] mon_e;
  int          n_cmp = 0;
  int          n_err = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  assign out_ready = rand_en ? ordy_rand : ordy_fix;

  always @(negedge clk) ordy_rand = ($urandom_range(0, 3) != 0);

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  multiplier_nbit_pipe_hs #(
    .WIDTH  (WIDTH),
    .LATENCY(LATENCY),
    .SHIFT  (SHIFT)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .in_signed(in_signed),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_q    (out_q)
`ifdef MULT_ROUND_EN
    ,
    .q_rnd    (q_rnd)
`endif
  );

  // ---------------- checking helpers ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [55:0] model(input logic [15:0] av, input logic [15:0] bv,
                                        input logic sv);
    longint pa, pb, p, r;
    pa = sv ? longint'($signed(av)) : longint'({48'd0, av});
    pb = sv ? longint'($signed(bv)) : longint'({48'd0, bv});
    p  = pa * pb;
    r  = (p + 64'sd128) >>> 8;
    return {r[23:0], p[31:0]};
  endfunction

  // ---------------- driver tasks ----------------
  // Called at a falling edge; returns at the falling edge after the accepting edge.
  task automatic send_exp(input logic [15:0] av, input logic [15:0] bv, input logic sv,
                          input logic [31:0] ep, input logic [23:0] er);
    int guard;
    guard     = 0;
    a         = av;
    b         = bv;
    in_signed = sv;
    in_valid  = 1'b1;
    #1;
    while (!in_ready && guard < 1000) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (guard >= 1000) check("in_ready_timeout", 64'(in_ready), 64'd1);
    else exp_q.push_back({er, ep});
    @(negedge clk);
  endtask

  task automatic send_model(input logic [15:0] av, input logic [15:0] bv, input logic sv);
    logic [55:0] m;
    m = model(av, bv, sv);
    send_exp(av, bv, sv, m[31:0], m[55:32]);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    #2;
    if (rstn && out_valid && out_ready) begin
      check("out_has_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("out_q", 64'(out_q), 64'(mon_e[31:0]));
`ifdef MULT_ROUND_EN
        check("q_rnd", 64'(q_rnd), 64'(mon_e[55:32]));
`endif
      end
    end
  end

  // ---------------- directed + random sequence ----------------
  logic [15:0] h_a, h_b;
  logic        h_s;
  int          guard;

  initial begin
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_q", 64'(out_q), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
`ifdef MULT_ROUND_EN
    check("rst_q_rnd", 64'(q_rnd), 64'd0);
`endif
    rstn = 1'b1;
    @(negedge clk);
    check("idle_in_ready", 64'(in_ready), 64'd1);

    // Unsigned max, with exact latency
    send_exp(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, 24'hFFFE00);
    in_valid = 1'b0;
    check("t1_lat_c1", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("t1_lat_c2", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("t1_lat_c3", 64'(out_valid), 64'd1);
    idle(3);

    // Signed corners, then rounding corners
    send_exp(16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001, 24'h000000);
    send_exp(16'h8000, 16'h7FFF, 1'b1, 32'hC0008000, 24'hC00080);
    send_exp(16'h0018, 16'h0010, 1'b0, 32'h00000180, 24'h000002);
    send_exp(16'hFFF0, 16'h0008, 1'b1, 32'hFFFFFF80, 24'h000000);
    idle(6);
    check("t2_drain", 64'(exp_q.size()), 64'd0);

    // 10 back-to-back items with random mode
    for (int i = 0; i < 10; i++)
      send_model(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
    idle(6);
    check("t3_drain", 64'(exp_q.size()), 64'd0);

    // Fill the pipe against a stalled output, then hold for 5 clocks
    ordy_fix = 1'b0;
    for (int i = 0; i < 3; i++)
      send_model(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
    h_a = 16'($urandom);
    h_b = 16'($urandom);
    h_s = 1'($urandom_range(0, 1));
    a = h_a;
    b = h_b;
    in_signed = h_s;
    in_valid = 1'b1;
    check("t3_full_in_ready", 64'(in_ready), 64'd0);
    check("t3_full_out_valid", 64'(out_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t3_hold_in_ready", 64'(in_ready), 64'd0);
      check("t3_hold_out_valid", 64'(out_valid), 64'd1);
      check("t3_hold_out_q", 64'(out_q), 64'(exp_q[0][31:0]));
    end
    ordy_fix = 1'b1;
    send_model(h_a, h_b, h_s);
    idle(6);
    check("t3_stall_drain", 64'(exp_q.size()), 64'd0);

    // Reset with items in flight
    for (int i = 0; i < 3; i++)
      send_model(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
    in_valid = 1'b0;
    rstn = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("t4_rst_out_valid", 64'(out_valid), 64'd0);
    check("t4_rst_out_q", 64'(out_q), 64'd0);
    check("t4_rst_in_ready", 64'(in_ready), 64'd0);
    rstn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t4_no_stale", 64'(out_valid), 64'd0);
    end
    check("t4_in_ready_back", 64'(in_ready), 64'd1);

    // Random stream with random gaps and back-pressure
    rand_en = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      send_model(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
    end
    in_valid = 1'b0;
    ordy_fix = 1'b1;
    rand_en  = 1'b0;
    guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    check("t6_drain", 64'(exp_q.size()), 64'd0);
    check("t6_out_valid_idle", 64'(out_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
